fwd_hazard_ctrl: RTL and testbench

//  Forwarding and load-use hazard controller for the 5-stage pipeline. Tracks the destination

---
 rtl/pipeline_pkg.sv | 29 ++
 rtl/fwd_sel_logic.sv | 37 +++
 rtl/fwd_hazard_ctrl.sv | 91 +++++++++
 tb/tb_fwd_hazard_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the forwarding/hazard controller.
//   REG_ADDR_W  : architectural register index width (32 regs, x0 reads as zero)
//   fwd_sel_e   : operand mux_3 select encoding used in the EX stage
//   idex_tag_t  : tag record carried by the ID/EX pipeline register
//   wb_tag_t    : tag record carried by EX/MEM and MEM/WB
package pipeline_pkg;

    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        FWD_REGFILE = 2'b00,
        FWD_MEMWB   = 2'b01,
        FWD_EXMEM   = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } idex_tag_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
    } wb_tag_t;

endpackage

// File: rtl/fwd_sel_logic.sv
// Combinational forwarding select for one EX-stage source operand.
//   i_rs        : source register of the instruction in EX
//   i_exmem_rd  : destination of the instruction in EX/MEM
//   i_exmem_rw  : EX/MEM instruction writes the register file
//   i_memwb_rd  : destination of the instruction in MEM/WB
//   i_memwb_rw  : MEM/WB instruction writes the register file
//   o_sel       : 10 = EX/MEM result, 01 = MEM/WB result, 00 = register file
module fwd_sel_logic #(
    parameter int unsigned REG_ADDR_W = pipeline_pkg::REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] i_rs,
    input  logic [REG_ADDR_W-1:0] i_exmem_rd,
    input  logic                  i_exmem_rw,
    input  logic [REG_ADDR_W-1:0] i_memwb_rd,
    input  logic                  i_memwb_rw,
    output logic [1:0]            o_sel
);
    import pipeline_pkg::*;

    logic w_exmem_hit;
    logic w_memwb_hit;

    // x0 is never a real producer, so a zero destination never matches.
    assign w_exmem_hit = i_exmem_rw && (i_exmem_rd != '0) && (i_exmem_rd == i_rs);
    assign w_memwb_hit = i_memwb_rw && (i_memwb_rd != '0) && (i_memwb_rd == i_rs);

    // The younger EX/MEM value wins when both stages hold the same register.
    always_comb begin
        o_sel = FWD_REGFILE;
        if (w_exmem_hit) begin
            o_sel = FWD_EXMEM;
        end else if (w_memwb_hit) begin
            o_sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller for the 5-stage pipeline.
// Tracks destination tags in ID/EX, EX/MEM and MEM/WB and drives the EX
// operand mux_3 selects plus a load-use stall.
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   enable            : pipeline advance; 0 freezes all tag registers
//   flush             : squash the instruction entering ID/EX
//   id_rs1/rs2/rd     : register fields of the instruction in ID
//   id_reg_write      : ID instruction writes the register file
//   id_mem_read       : ID instruction is a load
//   fwd_sel_a/b       : operand-A/B selects (00 regfile, 01 MEM/WB, 10 EX/MEM)
//   stall             : hold PC and IF/ID, bubble ID/EX
module fwd_hazard_ctrl #(
    parameter int unsigned REG_ADDR_W     = pipeline_pkg::REG_ADDR_W,
    parameter bit          LOAD_USE_STALL = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  flush,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    output logic [1:0]            fwd_sel_a,
    output logic [1:0]            fwd_sel_b,
    output logic                  stall
);
    import pipeline_pkg::*;

    idex_tag_t r_idex;
    wb_tag_t   r_exmem;
    wb_tag_t   r_memwb;
    idex_tag_t w_idex_next;
    logic      w_stall;

    // Load in EX whose result the ID instruction needs; a flushed ID
    // instruction is discarded anyway, so it cannot cause a stall.
    always_comb begin
        w_stall = 1'b0;
        if (LOAD_USE_STALL) begin
            w_stall = r_idex.mem_read && (r_idex.rd != '0) &&
                      ((r_idex.rd == id_rs1) || (r_idex.rd == id_rs2)) && !flush;
        end
    end

    always_comb begin
        w_idex_next = '0;
        if (!(flush || w_stall)) begin
            w_idex_next.rs1       = id_rs1;
            w_idex_next.rs2       = id_rs2;
            w_idex_next.rd        = id_rd;
            w_idex_next.reg_write = id_reg_write;
            w_idex_next.mem_read  = id_mem_read;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idex  <= '0;
            r_exmem <= '0;
            r_memwb <= '0;
        end else if (enable) begin
            r_idex            <= w_idex_next;
            r_exmem.rd        <= r_idex.rd;
            r_exmem.reg_write <= r_idex.reg_write;
            r_memwb           <= r_exmem;
        end
    end

    fwd_sel_logic #(.REG_ADDR_W(REG_ADDR_W)) u_sel_a (
        .i_rs       (r_idex.rs1),
        .i_exmem_rd (r_exmem.rd),
        .i_exmem_rw (r_exmem.reg_write),
        .i_memwb_rd (r_memwb.rd),
        .i_memwb_rw (r_memwb.reg_write),
        .o_sel      (fwd_sel_a)
    );

    fwd_sel_logic #(.REG_ADDR_W(REG_ADDR_W)) u_sel_b (
        .i_rs       (r_idex.rs2),
        .i_exmem_rd (r_exmem.rd),
        .i_exmem_rw (r_exmem.reg_write),
        .i_memwb_rd (r_memwb.rd),
        .i_memwb_rw (r_memwb.reg_write),
        .o_sel      (fwd_sel_b)
    );

    assign stall = w_stall;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
module tb_fwd_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       flush;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [4:0] id_rd;
    logic       id_reg_write;
    logic       id_mem_read;
    logic [1:0] fwd_sel_a;
    logic [1:0] fwd_sel_b;
    logic       stall;

    int checks;
    int errors;

    fwd_hazard_ctrl #(.REG_ADDR_W(5), .LOAD_USE_STALL(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .flush        (flush),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .fwd_sel_a    (fwd_sel_a),
        .fwd_sel_b    (fwd_sel_b),
        .stall        (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the instructions occupying EX, MEM and WB.
    typedef struct {
        int rs1;
        int rs2;
        int rd;
        bit rw;
        bit mr;
    } instr_t;

    instr_t pipe[3]; // 0 = in EX, 1 = in MEM, 2 = in WB

    function automatic instr_t nop();
        instr_t n;
        n.rs1 = 0; n.rs2 = 0; n.rd = 0; n.rw = 0; n.mr = 0;
        return n;
    endfunction

    // The closest older writer of the register supplies the value.
    function automatic int model_sel(int src);
        for (int i = 1; i <= 2; i++) begin
            if (pipe[i].rw && pipe[i].rd != 0 && pipe[i].rd == src)
                return (i == 1) ? 2 : 1;
        end
        return 0;
    endfunction

    function automatic bit model_stall();
        if (flush) return 0;
        if (!pipe[0].mr || pipe[0].rd == 0) return 0;
        return (pipe[0].rd == int'(id_rs1)) || (pipe[0].rd == int'(id_rs2));
    endfunction

    task automatic cycle();
        bit     s;
        instr_t in;
        s = model_stall();
        in.rs1 = id_rs1; in.rs2 = id_rs2; in.rd = id_rd;
        in.rw = id_reg_write; in.mr = id_mem_read;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 3; i++) pipe[i] = nop();
        end else if (enable) begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = (flush || s) ? nop() : in;
        end
        #1;
    endtask

    task automatic set_id(int rs1, int rs2, int rd, bit rw, bit mr);
        id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_rd = 5'(rd);
        id_reg_write = rw; id_mem_read = mr;
        #1;
    endtask

    task automatic drain();
        set_id(0, 0, 0, 0, 0);
        repeat (3) cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; flush = 1'b0;
        for (int c = 0; c < 2; c++) begin
            set_id($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                   1'($urandom), 1'($urandom));
            cycle();
            checks++;
            if (fwd_sel_a !== 2'b00 || fwd_sel_b !== 2'b00 || stall !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold c%0d: sel_a=%b sel_b=%b stall=%b want 00 00 0",
                         c, fwd_sel_a, fwd_sel_b, stall);
            end
        end
        rst = 1'b0;
        set_id(7, 7, 7, 1, 1);
        checks++;
        if (fwd_sel_a !== 2'b00 || fwd_sel_b !== 2'b00 || stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_after: sel_a=%b sel_b=%b stall=%b want 00 00 0",
                     fwd_sel_a, fwd_sel_b, stall);
        end
    endtask

    task automatic test_forward_distance();
        logic [1:0] want[3];
        want[0] = 2'b10; want[1] = 2'b01; want[2] = 2'b00;
        for (int gap = 0; gap < 3; gap++) begin
            drain();
            set_id(1, 2, 5, 1, 0);              // add x5, x1, x2
            cycle();
            for (int g = 0; g < gap; g++) begin
                set_id(10, 11, 12, 1, 0);       // unrelated add x12
                cycle();
            end
            set_id(5, 5, 6, 1, 0);              // sub x6, x5, x5
            cycle();
            checks++;
            if (fwd_sel_a !== want[gap] || fwd_sel_b !== want[gap] || stall !== 1'b0) begin
                errors++;
                $display("FAIL fwd_gap%0d: sel_a=%b sel_b=%b stall=%b want %b %b 0",
                         gap, fwd_sel_a, fwd_sel_b, stall, want[gap], want[gap]);
            end
        end
    endtask

    task automatic test_load_use();
        drain();
        set_id(2, 0, 7, 1, 1);                  // lw x7
        cycle();
        set_id(7, 1, 8, 1, 0);                  // add x8, x7, x1
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL lu_stall_on: stall=%b want 1", stall);
        end
        cycle();                                // bubble enters EX, add held in ID
        checks++;
        if (stall !== 1'b0 || fwd_sel_a !== 2'b00 || fwd_sel_b !== 2'b00) begin
            errors++;
            $display("FAIL lu_bubble: stall=%b sel_a=%b sel_b=%b want 0 00 00",
                     stall, fwd_sel_a, fwd_sel_b);
        end
        cycle();                                // add in EX, load in MEM/WB
        checks++;
        if (fwd_sel_a !== 2'b01 || fwd_sel_b !== 2'b00 || stall !== 1'b0) begin
            errors++;
            $display("FAIL lu_consumer: sel_a=%b sel_b=%b stall=%b want 01 00 0",
                     fwd_sel_a, fwd_sel_b, stall);
        end
    endtask

    task automatic test_priority();
        drain();
        set_id(1, 1, 3, 1, 0);
        cycle();
        set_id(2, 2, 3, 1, 0);
        cycle();
        set_id(3, 3, 4, 1, 0);
        cycle();
        checks++;
        if (fwd_sel_a !== 2'b10 || fwd_sel_b !== 2'b10) begin
            errors++;
            $display("FAIL priority: sel_a=%b sel_b=%b want 10 10", fwd_sel_a, fwd_sel_b);
        end
    endtask

    task automatic test_x0();
        drain();
        set_id(1, 2, 0, 1, 0);                  // writes x0
        cycle();
        set_id(0, 0, 9, 1, 0);                  // reads x0
        cycle();
        checks++;
        if (fwd_sel_a !== 2'b00 || fwd_sel_b !== 2'b00) begin
            errors++;
            $display("FAIL x0_fwd: sel_a=%b sel_b=%b want 00 00", fwd_sel_a, fwd_sel_b);
        end
        drain();
        set_id(1, 0, 0, 1, 1);                  // lw x0
        cycle();
        set_id(0, 0, 9, 1, 0);
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL x0_stall: stall=%b want 0", stall);
        end
        cycle();
    endtask

    task automatic test_flush_freeze();
        drain();
        set_id(2, 0, 9, 1, 1);                  // lw x9
        cycle();
        flush = 1'b1;
        set_id(9, 4, 10, 1, 0);                 // dependent, squashed
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_mask: stall=%b want 0", stall);
        end
        cycle();
        flush = 1'b0;
        set_id(9, 4, 10, 1, 0);
        // A non-zeroed ID/EX would still hold the load and stall here.
        checks++;
        if (stall !== 1'b0 || fwd_sel_a !== 2'b00 || fwd_sel_b !== 2'b00) begin
            errors++;
            $display("FAIL flush_bubble: stall=%b sel_a=%b sel_b=%b want 0 00 00",
                     stall, fwd_sel_a, fwd_sel_b);
        end
        cycle();
        checks++;
        if (fwd_sel_a !== 2'b01 || fwd_sel_b !== 2'b00) begin
            errors++;
            $display("FAIL pre_freeze: sel_a=%b sel_b=%b want 01 00", fwd_sel_a, fwd_sel_b);
        end
        enable = 1'b0;
        for (int c = 0; c < 3; c++) begin
            set_id($urandom_range(10, 31), $urandom_range(10, 31), $urandom_range(0, 31), 1, 0);
            cycle();
            checks++;
            if (fwd_sel_a !== 2'b01 || fwd_sel_b !== 2'b00 || stall !== 1'b0) begin
                errors++;
                $display("FAIL freeze c%0d: sel_a=%b sel_b=%b stall=%b want 01 00 0",
                         c, fwd_sel_a, fwd_sel_b, stall);
            end
        end
        enable = 1'b1;
        drain();
    endtask

    task automatic test_random();
        int es_a, es_b;
        bit es;
        for (int n = 0; n < 400; n++) begin
            rst    = ($urandom_range(0, 99) < 2);
            enable = ($urandom_range(0, 99) < 85);
            flush  = ($urandom_range(0, 99) < 10);
            set_id($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   1'($urandom), ($urandom_range(0, 99) < 35));
            es_a = model_sel(pipe[0].rs1);
            es_b = model_sel(pipe[0].rs2);
            es   = model_stall();
            checks++;
            if (int'(fwd_sel_a) !== es_a || int'(fwd_sel_b) !== es_b || stall !== es) begin
                errors++;
                $display("FAIL random n%0d: sel_a=%b sel_b=%b stall=%b want %0d %0d %0d",
                         n, fwd_sel_a, fwd_sel_b, stall, es_a, es_b, es);
            end
            cycle();
        end
        rst = 1'b0; enable = 1'b1; flush = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; enable = 1'b1; flush = 1'b0;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_reg_write = 1'b0; id_mem_read = 1'b0;
        for (int i = 0; i < 3; i++) pipe[i] = nop();
        test_reset();
        test_forward_distance();
        test_load_use();
        test_priority();
        test_x0();
        test_flush_freeze();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
